// File: rtl/result_reader_pkg.sv
// Shared definitions for the result memory reader and the control unit that fills it:
// FSM encoding, record/memory geometry defaults and the word-address wrap helper.
package result_reader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_CAPT = 2'd2;
  localparam state_t ST_HOLD = 2'd3;

  localparam int REC_WORDS_DEF = 7;
  localparam int MEM_DEPTH_DEF = 10000;

  // Next word address, wrapping to 0 after the last memory location.
  function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input logic [31:0] depth);
    if (addr == depth - 32'd1) begin
      return 32'd0;
    end else begin
      return addr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/result_reader_pend_counter.sv
// Pending-record counter: up on commit, down on record completion, saturating at
// all-ones with a sticky overflow flag that only reset clears.
module pend_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W-1:0] MAX  = {W{1'b1}};
  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  // Counter and sticky overflow; a simultaneous commit and completion cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= ZERO;
      overflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count == MAX) begin
            overflow <= 1'b1;
          end else begin
            count <= count + ONE;
          end
        end
        2'b01: begin
          if (count != ZERO) begin
            count <= count - ONE;
          end else begin
            count <= count;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: rtl/result_reader.sv
// Streams committed 7-word result records out of the result memory onto a valid/ready
// stream. Define RESULT_READER_CKSUM_EN to append an XOR checksum word to each record.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REC_WORDS = REC_WORDS_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int PEND_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_commit,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [PEND_W-1:0] pending,
  output logic              busy,
  output logic              overflow
);

  localparam int IDX_W = $clog2(REC_WORDS + 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
`ifdef RESULT_READER_CKSUM_EN
  localparam logic [IDX_W-1:0] CK_IDX   = IDX_W'(REC_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_WORDS);
  localparam logic [IDX_W-1:0] DLST_IDX = IDX_W'(REC_WORDS - 1);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_WORDS - 1);
`endif

  state_t            state_r;
  state_t            next_state_s;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_next_s;
  logic [IDX_W-1:0]  word_idx_r;
  logic [DATA_W-1:0] capt_data_s;
  logic              hs_s;
  logic              is_last_s;
  logic              rec_done_s;
  logic              ck_next_s;
  logic              adv_s;
`ifdef RESULT_READER_CKSUM_EN
  logic [DATA_W-1:0] cksum_r;
`endif

  // Handshake decode, pointer advance and the word captured in CAPT.
  always_comb begin
    hs_s       = (state_r == ST_HOLD) && m_valid && m_ready;
    is_last_s  = (word_idx_r == LAST_IDX);
    rec_done_s = hs_s && is_last_s;
`ifdef RESULT_READER_CKSUM_EN
    // The checksum word is built from registers, so it skips READ and keeps rd_ptr.
    ck_next_s   = hs_s && (word_idx_r == DLST_IDX);
    adv_s       = hs_s && (word_idx_r != CK_IDX);
    capt_data_s = (word_idx_r == CK_IDX) ? cksum_r : mem_rdata;
`else
    ck_next_s   = 1'b0;
    adv_s       = hs_s;
    capt_data_s = mem_rdata;
`endif
    if (adv_s) begin
      rd_ptr_next_s = ADDR_W'(wrap_inc(32'(rd_ptr_r), 32'(MEM_DEPTH)));
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pending != {PEND_W{1'b0}}) begin
          next_state_s = ST_READ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_READ: next_state_s = ST_CAPT;
      ST_CAPT: next_state_s = ST_HOLD;
      ST_HOLD: begin
        if (!hs_s) begin
          next_state_s = ST_HOLD;
        end else if (is_last_s) begin
          next_state_s = ST_IDLE;
        end else if (ck_next_s) begin
          next_state_s = ST_CAPT;
        end else begin
          next_state_s = ST_READ;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM, read-port and stream registers; mem_re/mem_addr are issued on entry to READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rd_ptr_r   <= {ADDR_W{1'b0}};
      word_idx_r <= IDX_ZERO;
      mem_re     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      m_data     <= {DATA_W{1'b0}};
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      busy     <= (next_state_s != ST_IDLE);
      rd_ptr_r <= rd_ptr_next_s;
      mem_re   <= (next_state_s == ST_READ);
      if (next_state_s == ST_READ) begin
        mem_addr <= rd_ptr_next_s;
      end else begin
        mem_addr <= mem_addr;
      end
      if (state_r == ST_CAPT) begin
        m_data  <= capt_data_s;
        m_valid <= 1'b1;
        m_last  <= is_last_s;
      end else if (hs_s) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        m_valid <= m_valid;
      end
      if (hs_s) begin
        word_idx_r <= is_last_s ? IDX_ZERO : word_idx_r + IDX_ONE;
      end else begin
        word_idx_r <= word_idx_r;
      end
    end
  end

`ifdef RESULT_READER_CKSUM_EN
  // Running XOR of the record's memory words, restarted on word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cksum_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_CAPT) && (word_idx_r != CK_IDX)) begin
      cksum_r <= (word_idx_r == IDX_ZERO) ? mem_rdata : (cksum_r ^ mem_rdata);
    end else begin
      cksum_r <= cksum_r;
    end
  end
`endif

  pend_counter #(
    .W(PEND_W)
  ) u_pend_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (rec_commit),
    .dec      (rec_done_s),
    .count    (pending),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: a memory model plus a record-level reference
// that predicts every read address and stream word from the committed records.
module tb_result_reader;

  localparam int REC_WORDS = 7;
  localparam int MEM_DEPTH = 10000;
`ifdef RESULT_READER_CKSUM_EN
  localparam bit CKSUM = 1'b1;
`else
  localparam bit CKSUM = 1'b0;
`endif
  localparam int REC_CYC = 3 * REC_WORDS + (CKSUM ? 2 : 0);

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rec_commit;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [7:0]  pending;
  logic        busy;
  logic        overflow;

  logic [31:0] mem [0:MEM_DEPTH-1];
  exp_t        exp_q[$];
  int          addr_q[$];
  int          checks = 0;
  int          fails = 0;
  int          issued = 0;
  int          done_cnt = 0;
  int          model_ptr = 0;
  int          cyc = 0;

  result_reader dut (
    .clk        (clk),
    .rst        (rst),
    .rec_commit (rec_commit),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .pending    (pending),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Synchronous-read result memory model and cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: got timeout/unexpected event, expected normal progress (t=%0t)", name, $time);
  endtask

  // Reference: a record is REC_WORDS consecutive words (wrapping), plus an XOR word if enabled.
  task automatic push_record();
    logic [31:0] x;
    exp_t        e;
    int          a;
    x = 32'd0;
    for (int i = 0; i < REC_WORDS; i++) begin
      a = (model_ptr + i) % MEM_DEPTH;
      addr_q.push_back(a);
      x ^= mem[a];
      e.data = mem[a];
      e.last = !CKSUM && (i == REC_WORDS - 1);
      exp_q.push_back(e);
    end
    if (CKSUM) begin
      e.data = x;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
    model_ptr = (model_ptr + REC_WORDS) % MEM_DEPTH;
  endtask

  task automatic commit_now();
    rec_commit = 1'b1;
    push_record();
    issued++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rec_commit = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    addr_q.delete();
    model_ptr = 0;
    issued = 0;
    done_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      if (done_cnt == issued) break;
      @(posedge clk); #1;
    end
    if (k == bound) fail_now("drain_timeout");
  endtask

  // Monitor: compares every read address and every handshaken word against the queues.
  initial begin
    logic        held = 1'b0;
    logic [31:0] held_data = 32'd0;
    logic        held_last = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", m_data, held_data);
          check("hold_last", 32'(m_last), 32'(held_last));
        end
        if (mem_re) begin
          if (addr_q.size() == 0) fail_now("unexpected_read");
          else check("rd_addr", mem_addr, 32'(addr_q.pop_front()));
        end
        if (m_valid) begin
          check("no_read_while_valid", 32'(mem_re), 32'd0);
          check("busy_while_valid", 32'(busy), 32'd1);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_word");
          end else begin
            e = exp_q.pop_front();
            check("m_data", m_data, e.data);
            check("m_last", 32'(m_last), 32'(e.last));
            if (e.last) done_cnt++;
          end
        end
        held = m_valid && !m_ready;
        held_data = m_data;
        held_last = m_last;
      end
    end
  end

  initial begin
    int t0, t_rd, t_v, k;
    rst = 1'b1;
    rec_commit = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < REC_WORDS; i++) begin
      mem[i] = 32'h10 + 32'(i);
      mem[REC_WORDS + i] = 32'h10 + 32'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Single record, host always ready: latency, record time, pending 1 -> 0.
    m_ready = 1'b1;
    commit_now();
    @(posedge clk); #1;
    rec_commit = 1'b0;
    t0 = cyc;
    check("pending_after_commit", 32'(pending), 32'd1);
    t_rd = -1;
    t_v = -1;
    for (k = 0; k < 60; k++) begin
      if (mem_re && t_rd < 0) t_rd = cyc;
      if (m_valid && t_v < 0) t_v = cyc;
      if (m_valid && m_last) break;
      @(posedge clk); #1;
    end
    if (k == 60) fail_now("rec1_timeout");
    check("first_word_latency", 32'(t_v - t0), 32'd3);
    check("record_cycles", 32'(cyc + 1 - t_rd), 32'(REC_CYC));
    @(posedge clk); #1;
    check("pending_after_record", 32'(pending), 32'd0);
    check("busy_after_record", 32'(busy), 32'd0);

    // Backpressure on word 3 (0x13) for 5 cycles.
    commit_now();
    @(posedge clk); #1;
    rec_commit = 1'b0;
    for (k = 0; k < 60; k++) begin
      if (m_valid && m_data == 32'h13) break;
      @(posedge clk); #1;
    end
    if (k == 60) fail_now("word3_timeout");
    m_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_data", m_data, 32'h13);
      check("bp_no_read", 32'(mem_re), 32'd0);
    end
    m_ready = 1'b1;
    wait_drain(100);

    // Commit coinciding with the last handshake while pending is 1.
    do_reset();
    commit_now();
    @(posedge clk); #1;
    rec_commit = 1'b0;
    for (k = 0; k < 60; k++) begin
      if (m_valid && m_last) break;
      @(posedge clk); #1;
    end
    if (k == 60) fail_now("last_word_timeout");
    check("pending_before_overlap", 32'(pending), 32'd1);
    commit_now();
    @(posedge clk); #1;
    rec_commit = 1'b0;
    check("pending_overlap", 32'(pending), 32'd1);
    for (k = 0; k < 10; k++) begin
      if (mem_re) break;
      @(posedge clk); #1;
    end
    if (k == 10) fail_now("second_read_timeout");
    check("second_rec_addr", mem_addr, 32'd7);
    wait_drain(100);

    // Stream up to address 9996, then random traffic across the wrap.
    do_reset();
    for (k = 0; k < 60000; k++) begin
      if (done_cnt >= 1448) break;
      check("pending_model", 32'(pending), 32'(issued - done_cnt));
      if (issued < 1428) begin
        m_ready = 1'b1;
        if (issued - done_cnt < 3) commit_now();
      end else begin
        m_ready = ($urandom_range(0, 9) < 7);
        if (issued < 1448 && issued - done_cnt < 4 && $urandom_range(0, 3) == 0) commit_now();
      end
      @(posedge clk); #1;
      rec_commit = 1'b0;
    end
    if (k == 60000) fail_now("wrap_phase_timeout");
    m_ready = 1'b1;
    wait_drain(200);

    // Saturation: 256 commits with the host stalled, then reset.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 0) commit_now();
      else rec_commit = 1'b1;
      @(posedge clk); #1;
      if (i == 254) begin
        check("pending_255", 32'(pending), 32'd255);
        check("overflow_not_yet", 32'(overflow), 32'd0);
      end
    end
    rec_commit = 1'b0;
    check("pending_sat", 32'(pending), 32'd255);
    check("overflow_set", 32'(overflow), 32'd1);
    @(posedge clk); #1;
    check("overflow_sticky", 32'(overflow), 32'd1);
    do_reset();
    check("pending_cleared", 32'(pending), 32'd0);
    check("overflow_cleared", 32'(overflow), 32'd0);
    check("valid_cleared", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    commit_now();
    @(posedge clk); #1;
    rec_commit = 1'b0;
    for (k = 0; k < 10; k++) begin
      if (mem_re) break;
      @(posedge clk); #1;
    end
    if (k == 10) fail_now("post_reset_read_timeout");
    check("post_reset_addr", mem_addr, 32'd0);
    wait_drain(100);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
